// File: rtl/chroma_mask.sv
// rtl/chroma_mask.sv - RGB to Cb/Cr chroma-key mask stage with per-frame match counter
//
// Optional feature macro: OVERLAY_EN (matching pixels output as R=0,G=255,B=0).
//
// Ports:
//   CLOCK_50                 pixel clock
//   reset                    asynchronous active-low reset
//   in_valid/in_sof/in_eof   input pixel qualifier and frame markers
//   in_r/in_g/in_b           input pixel
//   crt/cbt                  Cr/Cb thresholds, sampled on the first pixel of a frame
//   out_valid/out_sof/out_eof  qualifier and markers delayed by LAT cycles
//   out_r/out_g/out_b        output pixel
//   out_mask                 pixel satisfied Cr >= crt and Cb <= cbt
//   frame_matches            match count of the last completed frame
//   frame_done               one-cycle pulse when frame_matches updates
module chroma_mask #(
  parameter int CNT_W = 20,
  parameter int LAT   = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  input  logic [7:0]       crt,
  input  logic [7:0]       cbt,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [7:0]       out_r,
  output logic [7:0]       out_g,
  output logic [7:0]       out_b,
  output logic             out_mask,
  output logic [CNT_W-1:0] frame_matches,
  output logic             frame_done
);

  if (LAT != 3) begin : g_lat_check
    $error("chroma_mask supports LAT=3 only");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Thresholds in force for the current frame.
  logic [7:0] crt_l, cbt_l;
  // Thresholds that apply to the incoming pixel: a sof pixel uses the new values.
  logic [7:0] crt_eff, cbt_eff;

  // Operands are zero-extended to 17 bits; partial sums never go negative,
  // so the unsigned arithmetic never wraps.
  logic [16:0] cb_sum, cr_sum;

  // Stage 1
  logic        v1, sof1, eof1;
  logic [7:0]  r1, g1, b1, crt1, cbt1;
  logic [16:0] cb_s1, cr_s1;
  // Stage 2
  logic        v2, sof2, eof2;
  logic [7:0]  r2, g2, b2, crt2, cbt2, cb2, cr2;

  logic                match;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                in_frame;
  logic                unused_bits;

  assign crt_eff = (in_valid && in_sof) ? crt : crt_l;
  assign cbt_eff = (in_valid && in_sof) ? cbt : cbt_l;

  assign cb_sum = 17'd32768 + {2'b00, in_b, 7'b0} - 17'd43 * {9'b0, in_r} - 17'd85 * {9'b0, in_g};
  assign cr_sum = 17'd32768 + {2'b00, in_r, 7'b0} - 17'd107 * {9'b0, in_g} - 17'd21 * {9'b0, in_b};

  assign unused_bits = ^{cb_s1[16], cb_s1[7:0], cr_s1[16], cr_s1[7:0]};

  assign match = v2 && (cr2 >= crt2) && (cb2 <= cbt2);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      crt_l <= 8'd150;
      cbt_l <= 8'd150;
    end else if (in_valid && in_sof) begin
      crt_l <= crt;
      cbt_l <= cbt;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; sof1 <= 1'b0; eof1 <= 1'b0;
      r1 <= '0; g1 <= '0; b1 <= '0; crt1 <= '0; cbt1 <= '0;
      cb_s1 <= '0; cr_s1 <= '0;
      v2 <= 1'b0; sof2 <= 1'b0; eof2 <= 1'b0;
      r2 <= '0; g2 <= '0; b2 <= '0; crt2 <= '0; cbt2 <= '0;
      cb2 <= '0; cr2 <= '0;
      out_valid <= 1'b0; out_sof <= 1'b0; out_eof <= 1'b0;
      out_r <= '0; out_g <= '0; out_b <= '0; out_mask <= 1'b0;
    end else begin
      v1    <= in_valid;
      sof1  <= in_valid && in_sof;
      eof1  <= in_valid && in_eof;
      r1    <= in_r;
      g1    <= in_g;
      b1    <= in_b;
      crt1  <= crt_eff;
      cbt1  <= cbt_eff;
      cb_s1 <= cb_sum;
      cr_s1 <= cr_sum;

      v2    <= v1;
      sof2  <= sof1;
      eof2  <= eof1;
      r2    <= r1;
      g2    <= g1;
      b2    <= b1;
      crt2  <= crt1;
      cbt2  <= cbt1;
      cb2   <= cb_s1[15:8];
      cr2   <= cr_s1[15:8];

      out_valid <= v2;
      out_sof   <= sof2;
      out_eof   <= eof2;
      out_mask  <= match;
`ifdef OVERLAY_EN
      if (match) begin
        out_r <= 8'd0;
        out_g <= 8'd255;
        out_b <= 8'd0;
      end else begin
        out_r <= r2;
        out_g <= g2;
        out_b <= b2;
      end
`else
      out_r <= r2;
      out_g <= g2;
      out_b <= b2;
`endif
    end
  end

  // in_frame starts set so an eof with no prior sof reports the count since reset.
  always_comb begin
    cnt_next = cnt;
    if (out_valid && out_sof) begin
      cnt_next = {{(CNT_W-1){1'b0}}, out_mask};
    end else if (out_valid && out_mask && in_frame && (cnt != CNT_MAX)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      in_frame      <= 1'b1;
      frame_matches <= '0;
      frame_done    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      frame_done <= out_valid && out_eof;
      if (out_valid && out_eof) begin
        frame_matches <= cnt_next;
        in_frame      <= 1'b0;
      end else if (out_valid && out_sof) begin
        in_frame      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chroma_mask.sv
// tb/tb_chroma_mask.sv - randomized self-checking bench for chroma_mask against a behavioural model
module tb_chroma_mask;

  localparam int CNT_W = 20;

  logic             CLOCK_50 = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
  logic [7:0]       in_r = '0, in_g = '0, in_b = '0;
  logic [7:0]       crt = 8'd150, cbt = 8'd150;
  logic             out_valid, out_sof, out_eof, out_mask, frame_done;
  logic [7:0]       out_r, out_g, out_b;
  logic [CNT_W-1:0] frame_matches;

  chroma_mask #(.CNT_W(CNT_W), .LAT(3)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .crt(crt), .cbt(cbt),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_mask(out_mask),
    .frame_matches(frame_matches), .frame_done(frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    bit       v, sof, eof, mask;
    bit [7:0] r, g, b;
  } exp_t;

  exp_t     q[$];
  int       n_checks = 0, n_pass = 0;
  bit [7:0] m_crt, m_cbt;
  int       m_cnt, m_fm, done_pulses;
  bit       m_in_frame, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.v = 0; e.sof = 0; e.eof = 0; e.mask = 0; e.r = 0; e.g = 0; e.b = 0;
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(bubble());
    q.push_back(bubble());
    m_crt = 8'd150; m_cbt = 8'd150;
    m_cnt = 0; m_fm = 0; m_done = 0; m_in_frame = 1;
  endtask

  task automatic sample_and_check();
    exp_t e;
    check("frame_matches", frame_matches, m_fm);
    check("frame_done", frame_done, m_done);
    if (frame_done) done_pulses++;
    if (q.size() == 0) begin
      check("model_queue_empty", 0, 1);
      return;
    end
    e = q.pop_front();
    check("out_valid", out_valid, e.v);
    check("out_sof", out_sof, e.sof);
    check("out_eof", out_eof, e.eof);
    check("out_mask", out_mask, e.mask);
    if (e.v) begin
      check("out_r", out_r, e.r);
      check("out_g", out_g, e.g);
      check("out_b", out_b, e.b);
    end
    m_done = 0;
    if (e.v) begin
      if (e.sof) m_cnt = e.mask;
      else if (m_in_frame && e.mask && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (e.eof) begin
        m_fm = m_cnt; m_done = 1; m_in_frame = 0;
      end else if (e.sof) m_in_frame = 1;
    end
  endtask

  task automatic drive(input bit v, input bit sof, input bit eof,
                       input bit [7:0] r, input bit [7:0] g, input bit [7:0] b,
                       input bit [7:0] crt_i, input bit [7:0] cbt_i);
    exp_t e;
    int   cb, cr;
    in_valid = v; in_sof = sof; in_eof = eof;
    in_r = r; in_g = g; in_b = b; crt = crt_i; cbt = cbt_i;
    if (v && sof) begin m_crt = crt_i; m_cbt = cbt_i; end
    cb = (32768 + 128 * b - 43 * r - 85 * g) / 256;
    cr = (32768 + 128 * r - 107 * g - 21 * b) / 256;
    e.v = v; e.sof = v && sof; e.eof = v && eof;
    e.mask = v && (cr >= m_crt) && (cb <= m_cbt);
    e.r = r; e.g = g; e.b = b;
`ifdef OVERLAY_EN
    if (e.mask) begin e.r = 0; e.g = 255; e.b = 0; end
`endif
    q.push_back(e);
    @(posedge CLOCK_50);
    #1;
    sample_and_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 8'd0, 8'd0, 8'd0, crt, cbt);
  endtask

  task automatic px(input bit sof, input bit eof, input bit hit, input bit [7:0] c, input bit [7:0] b);
    if (hit) drive(1, sof, eof, 8'd200, 8'd100, 8'd80, c, b);
    else     drive(1, sof, eof, 8'd0, 8'd0, 8'd255, c, b);
  endtask

  initial begin
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_mask", out_mask, 0);
    check("rst_frame_matches", frame_matches, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b1;
    model_reset();

    // Plan points at 150/150, then the inclusive gray boundary.
    px(1, 0, 1, 8'd150, 8'd150);
    px(0, 1, 0, 8'd150, 8'd150);
    drive(1, 1, 1, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    drive(1, 1, 1, 8'd128, 8'd128, 8'd128, 8'd129, 8'd128);
    idle(4);

    // Ten-pixel frame, four matches, one bubble mid-frame.
    done_pulses = 0;
    px(1, 0, 1, 150, 150); px(0, 0, 0, 150, 150); px(0, 0, 1, 150, 150); px(0, 0, 0, 150, 150);
    drive(0, 1, 1, 8'd200, 8'd100, 8'd80, 8'd150, 8'd150);
    px(0, 0, 1, 150, 150); px(0, 0, 0, 150, 150); px(0, 0, 0, 150, 150);
    px(0, 0, 1, 150, 150); px(0, 0, 0, 150, 150); px(0, 1, 0, 150, 150);
    idle(4);
    check("frame10_count", frame_matches, 4);
    check("frame10_done_pulses", done_pulses, 1);

    // Mid-frame threshold change only takes effect at the next sof.
    px(1, 0, 1, 150, 150);
    px(0, 0, 1, 255, 150);
    px(0, 1, 1, 255, 150);
    px(1, 0, 1, 255, 150);
    px(0, 1, 1, 255, 150);
    idle(4);
    check("crt255_frame_count", frame_matches, 0);

    // Randomized frames with bubbles, varying thresholds and stray sof on bubbles.
    for (int f = 0; f < 40; f++) begin
      int       len;
      bit [7:0] c, b;
      len = $urandom_range(1, 12);
      c = 8'($urandom_range(90, 200));
      b = 8'($urandom_range(90, 200));
      for (int p = 0; p < len; p++) begin
        if ($urandom_range(0, 3) == 0)
          drive(0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        if ($urandom_range(0, 4) == 0) c = 8'($urandom);
        drive(1, p == 0, p == len - 1, 8'($urandom), 8'($urandom), 8'($urandom), c, b);
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    // Leave a nonzero frame count, then reset with a pixel in stage 2.
    px(1, 0, 1, 150, 150);
    px(0, 1, 1, 150, 150);
    idle(4);
    check("pre_reset_count", frame_matches, 2);
    px(1, 0, 1, 150, 150);
    px(0, 0, 1, 150, 150);
    reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_mask", out_mask, 0);
    check("async_out_r", out_r, 0);
    check("async_frame_matches", frame_matches, 0);
    in_valid = 0; in_sof = 0; in_eof = 0;
    repeat (3) begin
      @(posedge CLOCK_50);
      #1;
      check("rst_hold_frame_done", frame_done, 0);
      check("rst_hold_out_valid", out_valid, 0);
    end
    reset = 1'b1;
    model_reset();
    idle(3);
    check("post_reset_count", frame_matches, 0);

    // No sof since reset: default 150/150 thresholds and count accumulated from reset.
    px(0, 0, 1, 8'd255, 8'd0);
    px(0, 1, 1, 8'd255, 8'd0);
    idle(4);
    check("no_sof_count", frame_matches, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
